// File: rtl/paint_controller.sv
// -----------------------------------------------------------------------------
// paint_controller
//
// Cursor and brush controller for a 160x120 VGA paint canvas. On each
// move-rate tick the cursor steps one pixel in the requested direction,
// saturating at the configured bounds. If the pen or eraser is active, a 1x1
// or 3x3 brush footprint is then plotted around the new cursor. A clear
// request blanks the whole frame one pixel per cycle.
//
// Ports
//   clk        system clock, all state changes on its rising edge
//   reset      asynchronous, active-high reset
//   tick       one-cycle move-rate strobe (dropped while busy)
//   btn_*      active-high direction requests (already synchronised)
//   pen_down   paint colour_in at the cursor on each accepted tick
//   erase      paint colour 000 at the cursor on each accepted tick
//   colour_in  brush colour
//   brush_big  0 = 1x1 brush, 1 = 3x3 brush
//   clear_req  blank the full frame (held pending if it arrives mid-draw)
//   x, y       pixel address to the VGA adapter
//   colour     pixel colour to the VGA adapter
//   plot       pixel write strobe, one pixel per cycle while high
//   busy       high whenever a draw or clear sequence is in progress
//   cursor_x/y current cursor position
// -----------------------------------------------------------------------------
module paint_controller #(
    parameter logic [7:0] X_MIN  = 8'd10,
    parameter logic [7:0] X_MAX  = 8'd150,
    parameter logic [6:0] Y_MIN  = 7'd10,
    parameter logic [6:0] Y_MAX  = 7'd110,
    parameter logic [7:0] X_HOME = 8'd80,
    parameter logic [6:0] Y_HOME = 7'd60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       pen_down,
    input  logic       erase,
    input  logic [2:0] colour_in,
    input  logic       brush_big,
    input  logic       clear_req,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic [7:0] cursor_x,
    output logic [6:0] cursor_y
);

    localparam logic [7:0] FRAME_X_LAST = 8'd159;
    localparam logic [6:0] FRAME_Y_LAST = 7'd119;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cursor_x_q, cursor_x_d;
    logic [6:0] cursor_y_q, cursor_y_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d;
    logic       busy_q, busy_d;
    logic       pending_q, pending_d;   // clear requested while drawing
    logic       big_q, big_d;           // brush size latched for this draw
    logic [1:0] col_q, col_d;           // 3x3 brush column offset 0..2
    logic [1:0] row_q, row_d;           // 3x3 brush row offset 0..2
    logic [7:0] next_cx;
    logic [6:0] next_cy;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d    = state_q;
        cursor_x_d = cursor_x_q;
        cursor_y_d = cursor_y_q;
        x_d        = x_q;
        y_d        = y_q;
        colour_d   = colour_q;
        plot_d     = 1'b0;
        pending_d  = pending_q;
        big_d      = big_q;
        col_d      = col_q;
        row_d      = row_q;
        next_cx    = cursor_x_q;
        next_cy    = cursor_y_q;

        case (state_q)
            IDLE: begin
                if (clear_req || pending_q) begin
                    state_d   = CLEAR;
                    pending_d = 1'b0;
                    x_d       = 8'd0;
                    y_d       = 7'd0;
                    colour_d  = 3'b000;
                    plot_d    = 1'b1;
                end else if (tick) begin
                    // Opposing buttons cancel; saturation is a compare, not a clamp,
                    // so the unsigned arithmetic can never wrap.
                    if (btn_left && !btn_right && cursor_x_q > X_MIN)
                        next_cx = cursor_x_q - 8'd1;
                    else if (btn_right && !btn_left && cursor_x_q < X_MAX)
                        next_cx = cursor_x_q + 8'd1;
                    if (btn_up && !btn_down && cursor_y_q > Y_MIN)
                        next_cy = cursor_y_q - 7'd1;
                    else if (btn_down && !btn_up && cursor_y_q < Y_MAX)
                        next_cy = cursor_y_q + 7'd1;
                    cursor_x_d = next_cx;
                    cursor_y_d = next_cy;

                    if (pen_down || erase) begin
                        // First brush pixel is registered on the accepting edge so
                        // plot rises in the very next cycle.
                        state_d  = DRAW;
                        colour_d = erase ? 3'b000 : colour_in;
                        big_d    = brush_big;
                        col_d    = 2'd0;
                        row_d    = 2'd0;
                        x_d      = brush_big ? next_cx - 8'd1 : next_cx;
                        y_d      = brush_big ? next_cy - 7'd1 : next_cy;
                        plot_d   = 1'b1;
                    end
                end
            end

            DRAW: begin
                if (clear_req)
                    pending_d = 1'b1;
                if (!big_q || (col_q == 2'd2 && row_q == 2'd2)) begin
                    state_d = IDLE;
                    col_d   = 2'd0;
                    row_d   = 2'd0;
                end else begin
                    plot_d = 1'b1;
                    if (col_q == 2'd2) begin
                        col_d = 2'd0;
                        row_d = row_q + 2'd1;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                    // NOTE: blocking assignments in always_comb let col_d/row_d be reused right after they are set.
                    x_d = cursor_x_q - 8'd1 + {6'd0, col_d};
                    y_d = cursor_y_q - 7'd1 + {5'd0, row_d};
                end
            end

            CLEAR: begin
                if (x_q == FRAME_X_LAST && y_q == FRAME_Y_LAST) begin
                    state_d = IDLE;
                end else begin
                    plot_d = 1'b1;
                    if (x_q == FRAME_X_LAST) begin
                        x_d = 8'd0;
                        y_d = y_q + 7'd1;
                    end else begin
                        x_d = x_q + 8'd1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cursor_x_q <= X_HOME;
            cursor_y_q <= Y_HOME;
            x_q        <= 8'd0;
            y_q        <= 7'd0;
            colour_q   <= 3'b000;
            plot_q     <= 1'b0;
            busy_q     <= 1'b0;
            pending_q  <= 1'b0;
            big_q      <= 1'b0;
            col_q      <= 2'd0;
            row_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            cursor_x_q <= cursor_x_d;
            cursor_y_q <= cursor_y_d;
            x_q        <= x_d;
            y_q        <= y_d;
            colour_q   <= colour_d;
            plot_q     <= plot_d;
            busy_q     <= busy_d;
            pending_q  <= pending_d;
            big_q      <= big_d;
            col_q      <= col_d;
            row_q      <= row_d;
        end
    end

    assign x        = x_q;
    assign y        = y_q;
    assign colour   = colour_q;
    assign plot     = plot_q;
    assign busy     = busy_q;
    assign cursor_x = cursor_x_q;
    assign cursor_y = cursor_y_q;

endmodule

// File: tb/tb_paint_controller.sv
// -----------------------------------------------------------------------------
// tb_paint_controller
//
// Directed bench for paint_controller: reset state, 1x1 paint, 3x3 erase in
// raster order, cursor saturation and cancelling buttons, pending clear after
// a draw with a full-frame sweep, and reset aborting a clear.
// -----------------------------------------------------------------------------
module tb_paint_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick, btn_up, btn_down, btn_left, btn_right;
    logic       pen_down, erase, brush_big, clear_req;
    logic [2:0] colour_in;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy;
    logic [7:0] cursor_x;
    logic [6:0] cursor_y;

    int tests_run = 0;
    int tests_failed = 0;

    paint_controller dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .pen_down  (pen_down),
        .erase     (erase),
        .colour_in (colour_in),
        .brush_big (brush_big),
        .clear_req (clear_req),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .busy      (busy),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one clock edge and settle; inputs are driven and outputs sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        tick = 0; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        pen_down = 0; erase = 0; brush_big = 0; clear_req = 0; colour_in = 3'b000;
    endtask

    initial begin
        int bad;
        int plots;

        reset = 1'b1;
        idle_inputs();
        step();
        step();

        // Reset state
        check("rst_cursor_x", cursor_x, 80);
        check("rst_cursor_y", cursor_y, 60);
        check("rst_x",        x,        0);
        check("rst_y",        y,        0);
        check("rst_colour",   colour,   0);
        check("rst_plot",     plot,     0);
        check("rst_busy",     busy,     0);
        reset = 1'b0;
        step();
        check("post_rst_plot", plot, 0);

        // 1x1 paint moving right
        tick = 1; btn_right = 1; pen_down = 1; colour_in = 3'b101; brush_big = 0;
        step();
        idle_inputs();
        check("p1_cursor_x", cursor_x, 81);
        check("p1_cursor_y", cursor_y, 60);
        check("p1_plot",     plot,     1);
        check("p1_x",        x,        81);
        check("p1_y",        y,        60);
        check("p1_colour",   colour,   5);
        check("p1_busy",     busy,     1);
        step();
        check("p1_end_plot",   plot,   0);
        check("p1_end_busy",   busy,   0);
        check("p1_hold_x",     x,      81);
        check("p1_hold_colour", colour, 5);

        // Move back left without painting
        tick = 1; btn_left = 1;
        step();
        idle_inputs();
        check("mv_cursor_x", cursor_x, 80);
        check("mv_plot",     plot,     0);
        check("mv_busy",     busy,     0);

        // 3x3 erase moving up-left; junk inputs during the draw must be ignored
        tick = 1; btn_up = 1; btn_left = 1; erase = 1; brush_big = 1;
        step();
        tick = 1; btn_up = 0; btn_left = 0; btn_right = 1; btn_down = 1;
        erase = 0; pen_down = 1; colour_in = 3'b111; brush_big = 0;
        check("e3_cursor_x", cursor_x, 79);
        check("e3_cursor_y", cursor_y, 59);
        bad = 0;
        for (int i = 0; i < 9; i++) begin
            if (plot !== 1'b1 || busy !== 1'b1 || colour !== 3'b000 ||
                x !== 8'(78 + i % 3) || y !== 7'(58 + i / 3))
                bad++;
            step();
        end
        idle_inputs();
        check("e3_pixel_errors", bad,      0);
        check("e3_end_plot",     plot,     0);
        check("e3_end_busy",     busy,     0);
        check("e3_ignored_cx",   cursor_x, 79);
        check("e3_ignored_cy",   cursor_y, 59);
        check("e3_hold_x",       x,        80);
        check("e3_hold_y",       y,        60);

        // Drive to the bottom-right corner and saturate there
        plots = 0;
        for (int i = 0; i < 80; i++) begin
            tick = 1; btn_right = 1; btn_down = 1;
            step();
            if (plot !== 1'b0 || busy !== 1'b0) plots++;
        end
        check("sat_no_plot",  plots,    0);
        check("sat_cursor_x", cursor_x, 150);
        check("sat_cursor_y", cursor_y, 110);
        step();
        check("sat_again_x", cursor_x, 150);
        check("sat_again_y", cursor_y, 110);
        check("sat_busy",    busy,     0);
        idle_inputs();
        tick = 1; btn_left = 1; btn_right = 1; btn_up = 1;
        step();
        idle_inputs();
        check("lr_cancel_x", cursor_x, 150);
        check("lr_up_y",     cursor_y, 109);

        // 3x3 paint with a clear request arriving mid-draw
        tick = 1; pen_down = 1; brush_big = 1; colour_in = 3'b011;
        step();
        idle_inputs();
        bad = 0;
        for (int i = 0; i < 9; i++) begin
            clear_req = (i == 2);
            if (plot !== 1'b1 || colour !== 3'b011 ||
                x !== 8'(149 + i % 3) || y !== 7'(108 + i / 3))
                bad++;
            step();
        end
        clear_req = 0;
        check("pd_pixel_errors", bad,  0);
        check("pd_gap_plot",     plot, 0);
        check("pd_gap_busy",     busy, 0);
        step();
        check("clr_first_plot", plot,   1);
        check("clr_first_x",    x,      0);
        check("clr_first_y",    y,      0);
        check("clr_first_col",  colour, 0);
        check("clr_busy",       busy,   1);

        // Full sweep; ticks with buttons and a second clear_req are ignored
        bad = 0;
        for (int n = 0; n < 19200; n++) begin
            tick = 1; btn_left = 1; btn_up = 1;
            clear_req = (n == 100);
            if (plot !== 1'b1 || colour !== 3'b000 ||
                x !== 8'(n % 160) || y !== 7'(n / 160))
                bad++;
            if (n == 19199) begin
                check("clr_last_x", x, 159);
                check("clr_last_y", y, 119);
            end
            step();
        end
        idle_inputs();
        check("clr_pixel_errors", bad,      0);
        check("clr_end_plot",     plot,     0);
        check("clr_end_busy",     busy,     0);
        check("clr_cursor_x",     cursor_x, 150);
        check("clr_cursor_y",     cursor_y, 109);
        step();
        check("clr_no_rerun", plot, 0);

        // Reset in the middle of a clear
        clear_req = 1;
        step();
        clear_req = 0;
        for (int n = 0; n < 5000; n++)
            step();
        check("abort_at_x",    x,    40);
        check("abort_at_y",    y,    31);
        check("abort_at_plot", plot, 1);
        #2;
        reset = 1'b1;
        #1;
        check("abort_plot",     plot,     0);
        check("abort_busy",     busy,     0);
        check("abort_cursor_x", cursor_x, 80);
        check("abort_cursor_y", cursor_y, 60);
        check("abort_x",        x,        0);
        step();
        reset = 1'b0;
        plots = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (plot !== 1'b0 || busy !== 1'b0) plots++;
        end
        check("abort_quiet", plots, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/paint_controller.md
PAINT_CONTROLLER -- requirements
Module: paint_controller

Interface
REQ-001 Parameters SHALL be: X_MIN 10 (lowest cursor x); X_MAX 150 (highest cursor x); Y_MIN 10 (lowest cursor y); Y_MAX 110 (highest cursor y); X_HOME 80 (reset x); Y_HOME 60 (reset y).
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 tick  input  1  one-cycle move-rate strobe from the rate divider.
REQ-005 btn_up, btn_down, btn_left, btn_right  input  1 each  active-high direction requests, already synchronised.
REQ-006 pen_down  input  1  paint at cursor on each accepted tick.
REQ-007 erase  input  1  paint with colour 000 instead of colour_in.
REQ-008 colour_in  input  3  brush colour.
REQ-009 brush_big  input  1  0 = 1x1 brush, 1 = 3x3 brush.
REQ-010 clear_req  input  1  request to blank the whole 160x120 frame.
REQ-011 x  output  8  and  y  output  7: pixel address to the VGA adapter.
REQ-012 colour  output  3  pixel colour to the VGA adapter.
REQ-013 plot  output  1  write strobe; one pixel per cycle while high.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 cursor_x  output  8  and  cursor_y  output  7: current cursor position.

Function
REQ-016 FSM states SHALL be IDLE, DRAW and CLEAR; all outputs SHALL be registered.
REQ-017 In IDLE, clear_req (or a pending clear, REQ-025) SHALL take priority over tick: next state CLEAR, pending flag cleared.
REQ-018 In IDLE with tick=1 and no clear: dx = -1 if left only, +1 if right only, 0 if neither or both; dy = -1 if up only, +1 if down only, 0 if neither or both.
REQ-019 The new cursor SHALL be cursor+dx / cursor+dy saturated to [X_MIN,X_MAX] / [Y_MIN,Y_MAX] and SHALL update on the same edge; diagonal moves are allowed.
REQ-020 On that edge, if pen_down or erase is 1, the FSM SHALL enter DRAW and latch paint colour (000 if erase, else colour_in) and brush_big; otherwise it SHALL stay in IDLE with only the cursor moved.
REQ-021 DRAW SHALL use the updated cursor (cx,cy). It SHALL emit 1 pixel at (cx,cy) when brush_big=0, or 9 pixels in raster order from (cx-1,cy-1) to (cx+1,cy+1) (x fastest) when brush_big=1. plot=1 for exactly 1 or 9 consecutive cycles, starting the cycle after the accepting edge. Then return to IDLE.
REQ-022 CLEAR SHALL emit 19200 pixels: x 0..159 fastest, y 0..119, colour 000, plot=1 every cycle starting the cycle after entry. Then return to IDLE. The cursor SHALL be unchanged.
REQ-023 In IDLE, plot SHALL be 0; x, y and colour SHALL hold their last driven values.
REQ-024 tick SHALL be ignored (dropped, not queued) while busy=1; button, pen and colour inputs SHALL be ignored mid-DRAW (latched values used).
REQ-025 clear_req asserted during DRAW SHALL set a pending flag that is serviced on the first IDLE cycle; clear_req during CLEAR SHALL be ignored.
REQ-026 Brush pixels SHALL never leave the frame (guaranteed by bounds >= 1 from edges); arithmetic SHALL be unsigned at the port widths.

Reset
REQ-027 While reset=1 (asynchronously): state IDLE; cursor_x=X_HOME, cursor_y=Y_HOME; x=0, y=0, colour=000; plot=0; busy=0; pending clear cleared; pixel counters cleared.
REQ-028 Reset during DRAW or CLEAR SHALL abort the sequence immediately, with no further plot pulses after release until a new tick or clear_req.

Verification
REQ-029 After reset, tick with btn_right=1 and pen_down=1, colour_in=101, brush_big=0 -> cursor (81,60); one plot cycle at (81,60) with colour 101.
REQ-030 Cursor (80,60), tick with btn_up=btn_left=1, erase=1, brush_big=1 -> cursor (79,59); 9 plot cycles covering (78..80, 58..60) in raster order, colour 000; busy high 9 cycles.
REQ-031 Cursor (150,110), tick with btn_right=btn_down=1, pen_down=0 -> cursor stays (150,110); no plot; busy stays 0. Tick with btn_left=btn_right=1 -> no x change.
REQ-032 clear_req during a 3x3 DRAW -> the draw completes its 9 pixels, then CLEAR runs: 19200 plot cycles, first (0,0), last (159,119), colour 000; ticks during CLEAR cause no cursor change.
REQ-033 Reset asserted at pixel 5000 of CLEAR -> plot=0 and busy=0 immediately; cursor = (80,60); no plot after release without new stimulus.
